// File: rtl/window_minmax_pkg.sv
// Shared types and default parameters for the windowed min/max statistics stage.
package window_minmax_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } wm_state_t;

    // One-hot relation of a versus b
    typedef enum logic [2:0] {
        REL_LT = 3'b001,
        REL_EQ = 3'b010,
        REL_GT = 3'b100
    } cmp_rel_t;

    localparam int DEFAULT_DATA_W  = 4;
    localparam int DEFAULT_WIN_LEN = 8;

endpackage

// File: rtl/window_minmax_4bit_cmp_rel.sv
// Combinational unsigned magnitude compare of a against b, one-hot relation out.
module cmp_rel_4bit
    import window_minmax_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [2:0]        rel_o
);

    always_comb begin
        rel_o = REL_EQ;
        if (a_i > b_i) begin
            rel_o = REL_GT;
        end else if (a_i < b_i) begin
            rel_o = REL_LT;
        end
    end

endmodule

// File: rtl/window_minmax_4bit.sv
// Windowed min/max and predecessor-relation counter with valid/ready in and out.
// Optional early window close via the flush port when WINDOW_MINMAX_FLUSH_EN is defined.
module window_minmax_4bit
    import window_minmax_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int WIN_LEN = DEFAULT_WIN_LEN,
    parameter int CNT_W   = $clog2(WIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef WINDOW_MINMAX_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic [CNT_W-1:0]  out_gt_cnt,
    output logic [CNT_W-1:0]  out_eq_cnt,
    output logic [CNT_W-1:0]  out_lt_cnt,
    output logic [CNT_W-1:0]  out_len
);

    wm_state_t         state_q, state_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0]  gt_q, gt_d;
    logic [CNT_W-1:0]  eq_q, eq_d;
    logic [CNT_W-1:0]  lt_q, lt_d;
    logic [CNT_W-1:0]  len_q, len_d;

    logic [2:0] rel_prev;
    logic [2:0] rel_min;
    logic [2:0] rel_max;
    logic       accept;
    logic       consume;
    logic       first;
    logic       close_win;

    cmp_rel_4bit #(.DATA_W(DATA_W)) u_cmp_prev (
        .a_i   (in_data),
        .b_i   (prev_q),
        .rel_o (rel_prev)
    );

    cmp_rel_4bit #(.DATA_W(DATA_W)) u_cmp_min (
        .a_i   (in_data),
        .b_i   (min_q),
        .rel_o (rel_min)
    );

    cmp_rel_4bit #(.DATA_W(DATA_W)) u_cmp_max (
        .a_i   (in_data),
        .b_i   (max_q),
        .rel_o (rel_max)
    );

    // Ready is purely state-based so no combinational path exists from out_ready.
    assign in_ready  = (state_q == ACCUM) && !rst;
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign first     = (len_q == '0);

    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        max_d     = max_q;
        prev_d    = prev_q;
        gt_d      = gt_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        len_d     = len_q;
        close_win = 1'b0;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    len_d  = len_q + CNT_W'(1);
                    prev_d = in_data;
                    if (first) begin
                        min_d = in_data;
                        max_d = in_data;
                        gt_d  = '0;
                        eq_d  = '0;
                        lt_d  = '0;
                    end else if (rel_prev == REL_GT) begin
                        gt_d = gt_q + CNT_W'(1);
                        if (rel_max == REL_GT) max_d = in_data;
                    end else if (rel_prev == REL_LT) begin
                        lt_d = lt_q + CNT_W'(1);
                        if (rel_min == REL_LT) min_d = in_data;
                    end else begin
                        eq_d = eq_q + CNT_W'(1);
                    end
                    if (len_d == CNT_W'(WIN_LEN)) close_win = 1'b1;
                end
`ifdef WINDOW_MINMAX_FLUSH_EN
                // An empty window has nothing to report, so flush needs a sample.
                if (flush && (accept || !first)) close_win = 1'b1;
`endif
                if (close_win) state_d = HOLD;
            end
            HOLD: begin
                if (consume) begin
                    state_d = ACCUM;
                    min_d   = '0;
                    max_d   = '0;
                    prev_d  = '0;
                    gt_d    = '0;
                    eq_d    = '0;
                    lt_d    = '0;
                    len_d   = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            min_q   <= '0;
            max_q   <= '0;
            prev_q  <= '0;
            gt_q    <= '0;
            eq_q    <= '0;
            lt_q    <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            prev_q  <= prev_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            len_q   <= len_d;
        end
    end

    assign out_min    = min_q;
    assign out_max    = max_q;
    assign out_gt_cnt = gt_q;
    assign out_eq_cnt = eq_q;
    assign out_lt_cnt = lt_q;
    assign out_len    = len_q;

endmodule
